// File: rtl/cb_param_cfgchain.sv
// Parametrised connection block: channel tracks pass through, grid pins are driven by
// per-pin muxes whose selects load serially and go live only on a length-checked commit.
// Optional CB_READBACK_EN copies the active selects back into the shadow chain.

module cb_pin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = 3
) (
  input  logic [MUX_SIZE-1:0] cand,
  input  logic [SEL_W-1:0]    sel,
  output logic                pin
);
  // select 0 and codes above MUX_SIZE leave the pin disconnected (driven low)
  always_comb begin
    pin = 1'b0;
    for (int k = 0; k < MUX_SIZE; k++)
      if (sel == SEL_W'(k + 1)) pin = cand[k];
  end
endmodule

module cb_param_cfgchain #(
  parameter int CHAN_W       = 18,
  parameter int NUM_PINS     = 10,
  parameter int MUX_SIZE     = 6,
  parameter int PIN_STRIDE   = 2,
  parameter int TRACK_STRIDE = 3
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
`ifdef CB_READBACK_EN
  input  logic                ccff_readback,
`endif
  input  logic [CHAN_W-1:0]   chan_in,
  output logic [CHAN_W-1:0]   chan_out,
  output logic [NUM_PINS-1:0] grid_pin,
  output logic                ccff_tail,
  output logic                cfg_valid,
  output logic                cfg_err
);
  localparam int SEL_W = $clog2(MUX_SIZE + 1);
  localparam int L     = NUM_PINS * SEL_W;
  localparam int CNT_W = $clog2(L + 2);

  logic [L-1:0]     sh;
  logic [L-1:0]     act;
  logic [CNT_W-1:0] cnt;
  logic             commit_ok;
  logic             rb;

  assign chan_out  = chan_in;
  assign ccff_tail = sh[L-1];
  assign commit_ok = ccff_commit & ~ccff_shift_en & (cnt == CNT_W'(L));

`ifdef CB_READBACK_EN
  assign rb = ccff_readback & ~ccff_shift_en;
`else
  assign rb = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sh        <= '0;
      act       <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (ccff_shift_en)
        sh <= {sh[L-2:0], ccff_head};
      // an accepted commit makes active equal the old shadow, so shadow then stays put
      else if (rb && !commit_ok)
        sh <= act;

      if (ccff_commit || rb)
        cnt <= '0;
      else if (ccff_shift_en && cnt != CNT_W'(L + 1))
        cnt <= cnt + CNT_W'(1);

      if (commit_ok) begin
        act       <= sh;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else if (ccff_commit) begin
        cfg_err   <= 1'b1;
      end
    end
  end

  // candidate track indices are fixed at elaboration; no runtime modulo
  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [MUX_SIZE-1:0] cand;
    for (genvar k = 0; k < MUX_SIZE; k++) begin : g_cand
      localparam int IDX = (p * PIN_STRIDE + k * TRACK_STRIDE) % CHAN_W;
      assign cand[k] = chan_in[IDX];
    end
    cb_pin_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_mux (
      .cand (cand),
      .sel  (act[p*SEL_W +: SEL_W]),
      .pin  (grid_pin[p])
    );
  end
endmodule
